// File: rtl/pkt_src_arb_if.sv
// Bundle of source write ports, parser pktin port and status outputs for pkt_src_arb.
// The arbiter uses the slave modport; the sources/parser side uses master.
interface pkt_src_arb_if;
    logic         port_data_wr;
    logic [133:0] port_data;
    logic         port_valid_wr;
    logic         port_valid;
    logic         port_alf;
    logic         cpu_data_wr;
    logic [133:0] cpu_data;
    logic         cpu_valid_wr;
    logic         cpu_valid;
    logic         cpu_alf;
    logic         pktout_data_wr;
    logic [133:0] pktout_data;
    logic         pktout_valid_wr;
    logic         pktout_valid;
    logic         pktout_ready;
    logic         port_ovf;
    logic         cpu_ovf;
    logic [31:0]  port_pkt_cnt;
    logic [31:0]  cpu_pkt_cnt;

    modport slave (
        input  port_data_wr, port_data, port_valid_wr, port_valid,
        input  cpu_data_wr, cpu_data, cpu_valid_wr, cpu_valid,
        input  pktout_ready,
        output port_alf, cpu_alf,
        output pktout_data_wr, pktout_data, pktout_valid_wr, pktout_valid,
        output port_ovf, cpu_ovf, port_pkt_cnt, cpu_pkt_cnt
    );

    modport master (
        output port_data_wr, port_data, port_valid_wr, port_valid,
        output cpu_data_wr, cpu_data, cpu_valid_wr, cpu_valid,
        output pktout_ready,
        input  port_alf, cpu_alf,
        input  pktout_data_wr, pktout_data, pktout_valid_wr, pktout_valid,
        input  port_ovf, cpu_ovf, port_pkt_cnt, cpu_pkt_cnt
    );
endinterface

// File: rtl/pkt_src_arb.sv
// Packet-level round-robin arbiter: port path and CPU path into the parser pktin port.
// Optional per-source forwarded-packet counters under `PKT_SRC_ARB_STATS_EN.

// Show-ahead synchronous FIFO; full writes are dropped and flagged via full.
module pkt_src_arb_fifo #(
    parameter int W      = 134,
    parameter int AW     = 8,
    parameter int MARGIN = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full,
    output logic         alf_nxt
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] THR = (AW+1)'(DEPTH - MARGIN);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt, cnt_nxt;
    logic          push_ok, pop_ok;

    assign empty   = (cnt == '0);
    assign full    = cnt[AW];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_comb begin
        cnt_nxt = cnt;
        if (push_ok && !pop_ok)
            cnt_nxt = cnt + 1'b1;
        else if (!push_ok && pop_ok)
            cnt_nxt = cnt - 1'b1;
    end

    // Threshold on the post-update count so the registered flag tracks this edge.
    assign alf_nxt = (cnt_nxt >= THR);

    always_ff @(posedge clk)
        if (push_ok) mem[wr_ptr] <= din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt_nxt;
        end
    end
endmodule

// One requester: word FIFO, per-packet keep/drop FIFO, almost-full and overflow flags.
module pkt_src_arb_src #(
    parameter int W                = 134,
    parameter int DATA_AW          = 8,
    parameter int VALID_AW         = 4,
    parameter int DATA_ALF_MARGIN  = 128,
    parameter int VALID_ALF_MARGIN = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         data_wr,
    input  logic [W-1:0] data,
    input  logic         valid_wr,
    input  logic         valid,
    input  logic         data_pop,
    input  logic         valid_pop,
    output logic [W-1:0] head,
    output logic         head_valid,
    output logic         data_empty,
    output logic         eligible,
    output logic         alf,
    output logic         ovf
);
    logic d_full, d_alf_nxt;
    logic v_empty, v_full, v_alf_nxt;

    pkt_src_arb_fifo #(.W(W), .AW(DATA_AW), .MARGIN(DATA_ALF_MARGIN)) u_data (
        .clk(clk), .rst_n(rst_n), .push(data_wr), .din(data), .pop(data_pop),
        .dout(head), .empty(data_empty), .full(d_full), .alf_nxt(d_alf_nxt)
    );

    pkt_src_arb_fifo #(.W(1), .AW(VALID_AW), .MARGIN(VALID_ALF_MARGIN)) u_valid (
        .clk(clk), .rst_n(rst_n), .push(valid_wr), .din(valid), .pop(valid_pop),
        .dout(head_valid), .empty(v_empty), .full(v_full), .alf_nxt(v_alf_nxt)
    );

    // A buffered keep/drop flag means a whole packet is sitting in the word FIFO.
    assign eligible = !v_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alf <= 1'b0;
            ovf <= 1'b0;
        end else begin
            alf <= d_alf_nxt || v_alf_nxt;
            ovf <= ovf || (data_wr && d_full) || (valid_wr && v_full);
        end
    end
endmodule

module pkt_src_arb #(
    parameter int DATA_AW          = 8,
    parameter int VALID_AW         = 4,
    parameter int DATA_ALF_MARGIN  = 128,
    parameter int VALID_ALF_MARGIN = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    pkt_src_arb_if.slave  bus
);
    localparam int   NUM_SRC  = 2;
    localparam int   W        = 134;
    localparam logic SRC_PORT = 1'b0;
    localparam logic SRC_CPU  = 1'b1;

    typedef enum logic {IDLE, SEND} state_t;

    logic [NUM_SRC-1:0]        data_wr, valid_wr, valid_in;
    logic [NUM_SRC-1:0]        data_pop, valid_pop, data_empty, eligible, alf, ovf, head_valid;
    logic [NUM_SRC-1:0][W-1:0] data_in, head;

    state_t        state_q, state_d;
    logic          grant_q, grant_d;
    logic [W-1:0]  cur_word;
    logic          pop_any, is_tail;
    logic          out_data_wr, out_valid_wr, out_valid;
    logic [W-1:0]  out_data;

    assign data_wr  = {bus.cpu_data_wr,  bus.port_data_wr};
    assign data_in  = {bus.cpu_data,     bus.port_data};
    assign valid_wr = {bus.cpu_valid_wr, bus.port_valid_wr};
    assign valid_in = {bus.cpu_valid,    bus.port_valid};

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        pkt_src_arb_src #(
            .W(W), .DATA_AW(DATA_AW), .VALID_AW(VALID_AW),
            .DATA_ALF_MARGIN(DATA_ALF_MARGIN), .VALID_ALF_MARGIN(VALID_ALF_MARGIN)
        ) u_src (
            .clk(clk), .rst_n(rst_n),
            .data_wr(data_wr[s]), .data(data_in[s]),
            .valid_wr(valid_wr[s]), .valid(valid_in[s]),
            .data_pop(data_pop[s]), .valid_pop(valid_pop[s]),
            .head(head[s]), .head_valid(head_valid[s]),
            .data_empty(data_empty[s]), .eligible(eligible[s]),
            .alf(alf[s]), .ovf(ovf[s])
        );
    end

    // grant_q doubles as last_grant; it keeps pointing at the source being sent.
    assign cur_word = head[grant_q];
    assign pop_any  = (state_q == SEND) && !data_empty[grant_q];
    assign is_tail  = (cur_word[133:132] == 2'b10);

    always_comb begin
        data_pop             = '0;
        valid_pop            = '0;
        data_pop[grant_q]    = pop_any;
        valid_pop[grant_q]   = pop_any && is_tail;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= SRC_CPU;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (bus.pktout_ready && |eligible) begin
                    state_d = SEND;
                    if (&eligible)
                        grant_d = ~grant_q;
                    else
                        grant_d = eligible[SRC_CPU] ? SRC_CPU : SRC_PORT;
                end
            end
            SEND: begin
                if (pop_any && is_tail) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_wr  <= 1'b0;
            out_data     <= '0;
            out_valid_wr <= 1'b0;
            out_valid    <= 1'b0;
        end else begin
            out_data_wr  <= pop_any;
            out_valid_wr <= pop_any && is_tail;
            if (pop_any) out_data <= cur_word;
            if (pop_any && is_tail) out_valid <= head_valid[grant_q];
        end
    end

    assign bus.pktout_data_wr  = out_data_wr;
    assign bus.pktout_data     = out_data;
    assign bus.pktout_valid_wr = out_valid_wr;
    assign bus.pktout_valid    = out_valid;
    assign bus.port_alf        = alf[SRC_PORT];
    assign bus.cpu_alf         = alf[SRC_CPU];
    assign bus.port_ovf        = ovf[SRC_PORT];
    assign bus.cpu_ovf         = ovf[SRC_CPU];

`ifdef PKT_SRC_ARB_STATS_EN
    logic [NUM_SRC-1:0][31:0] pkt_cnt;

    // Counted at the tail pop: keep and drop packets alike, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt <= '0;
        end else begin
            for (int s = 0; s < NUM_SRC; s++)
                if (valid_pop[s]) pkt_cnt[s] <= pkt_cnt[s] + 32'd1;
        end
    end

    assign bus.port_pkt_cnt = pkt_cnt[SRC_PORT];
    assign bus.cpu_pkt_cnt  = pkt_cnt[SRC_CPU];
`else
    assign bus.port_pkt_cnt = 32'd0;
    assign bus.cpu_pkt_cnt  = 32'd0;
`endif
endmodule

// File: tb/tb_pkt_src_arb.sv
// Directed self-checking bench for pkt_src_arb; checks counters for either build
// of PKT_SRC_ARB_STATS_EN.
module tb_pkt_src_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pkt_src_arb_if bus ();

    pkt_src_arb dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int vwr_cnt = 0;

    typedef struct {
        int           c;
        logic [133:0] d;
        logic         vwr;
        logic         v;
    } ev_t;
    ev_t out_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.pktout_data_wr === 1'b1)
            out_q.push_back(ev_t'{cyc, bus.pktout_data, bus.pktout_valid_wr, bus.pktout_valid});
        if (bus.pktout_valid_wr === 1'b1) vwr_cnt++;
    end

    function automatic logic [133:0] mk(input logic [1:0] t, input int tag);
        return {t, 100'd0, 32'(tag)};
    endfunction

    function automatic logic [1:0] typ(input int i, input int n);
        if (i == 0)     return 2'b01;
        if (i == n - 1) return 2'b10;
        return 2'b11;
    endfunction

    task automatic clr_in();
        bus.port_data_wr = 0; bus.port_data = '0; bus.port_valid_wr = 0; bus.port_valid = 0;
        bus.cpu_data_wr  = 0; bus.cpu_data  = '0; bus.cpu_valid_wr  = 0; bus.cpu_valid  = 0;
    endtask

    task automatic drv(input logic pw, input logic [133:0] pd, input logic pvw, input logic pv,
                       input logic cw, input logic [133:0] cd, input logic cvw, input logic cv);
        @(posedge clk); #1;
        bus.port_data_wr = pw; bus.port_data = pd; bus.port_valid_wr = pvw; bus.port_valid = pv;
        bus.cpu_data_wr  = cw; bus.cpu_data  = cd; bus.cpu_valid_wr  = cvw; bus.cpu_valid  = cv;
    endtask

    task automatic drv_idle();
        @(posedge clk); #1;
        clr_in();
    endtask

    task automatic do_reset();
        clr_in();
        bus.pktout_ready = 0;
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        out_q.delete();
        vwr_cnt = 0;
    endtask

    task automatic test_reset();
        clr_in();
        bus.pktout_ready = 1;
        rst_n = 0;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({bus.pktout_data_wr, bus.pktout_valid_wr, bus.pktout_valid} !== 3'b000) begin
            n_fail++; $display("FAIL reset_strobes: got %b expected 000",
                {bus.pktout_data_wr, bus.pktout_valid_wr, bus.pktout_valid});
        end
        n_chk++;
        if (bus.pktout_data !== 134'd0) begin
            n_fail++; $display("FAIL reset_data: got %0h expected 0", bus.pktout_data);
        end
        n_chk++;
        if ({bus.port_alf, bus.cpu_alf, bus.port_ovf, bus.cpu_ovf} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0000",
                {bus.port_alf, bus.cpu_alf, bus.port_ovf, bus.cpu_ovf});
        end
        n_chk++;
        if ({bus.port_pkt_cnt, bus.cpu_pkt_cnt} !== 64'd0) begin
            n_fail++; $display("FAIL reset_cnt: got %0h/%0h expected 0/0", bus.port_pkt_cnt, bus.cpu_pkt_cnt);
        end
    endtask

    task automatic test_single_port();
        int wc = 0;
        do_reset();
        bus.pktout_ready = 1;
        for (int i = 0; i < 4; i++) begin
            drv(1, mk(typ(i, 4), 10 + i), i == 3, 1, 0, '0, 0, 0);
            if (i == 3) wc = cyc;
        end
        drv_idle();
        repeat (12) @(negedge clk);
        n_chk++;
        if (out_q.size() != 4) begin
            n_fail++; $display("FAIL single_count: got %0d expected 4", out_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_chk++;
                if (out_q[i].c != wc + 3 + i) begin
                    n_fail++; $display("FAIL single_cycle[%0d]: got %0d expected %0d", i, out_q[i].c, wc + 3 + i);
                end
                n_chk++;
                if (out_q[i].d !== mk(typ(i, 4), 10 + i)) begin
                    n_fail++; $display("FAIL single_data[%0d]: got %0h expected %0h", i, out_q[i].d, mk(typ(i, 4), 10 + i));
                end
                n_chk++;
                if (out_q[i].vwr !== (i == 3)) begin
                    n_fail++; $display("FAIL single_vwr[%0d]: got %b expected %b", i, out_q[i].vwr, i == 3);
                end
            end
            n_chk++;
            if (out_q[3].v !== 1'b1) begin
                n_fail++; $display("FAIL single_valid: got %b expected 1", out_q[3].v);
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 3; i++)
                drv(1, mk(typ(i, 3), 1000 + p * 10 + i), i == 2, 1,
                    1, mk(typ(i, 3), 2000 + p * 10 + i), i == 2, 1);
        drv_idle();
        @(posedge clk); #1;
        bus.pktout_ready = 1;
        repeat (40) @(negedge clk);
        n_chk++;
        if (out_q.size() != 18) begin
            n_fail++; $display("FAIL rr_count: got %0d expected 18", out_q.size());
        end else begin
            for (int e = 0; e < 18; e++) begin
                int j = e / 3;
                int i = e % 3;
                int tag = (j % 2 == 0 ? 1000 : 2000) + (j / 2) * 10 + i;
                n_chk++;
                if (out_q[e].d !== mk(typ(i, 3), tag) || out_q[e].vwr !== (i == 2)) begin
                    n_fail++; $display("FAIL rr_word[%0d]: got %0h/%b expected %0h/%b",
                        e, out_q[e].d, out_q[e].vwr, mk(typ(i, 3), tag), i == 2);
                end
                if (e > 0) begin
                    n_chk++;
                    if (out_q[e].c != out_q[e-1].c + (i == 0 ? 2 : 1)) begin
                        n_fail++; $display("FAIL rr_gap[%0d]: got %0d expected %0d",
                            e, out_q[e].c - out_q[e-1].c, i == 0 ? 2 : 1);
                    end
                end
            end
        end
    endtask

    task automatic test_ready_low();
        do_reset();
        for (int i = 0; i < 3; i++)
            drv(0, '0, 0, 0, 1, mk(typ(i, 3), 500 + i), i == 2, 1);
        drv_idle();
        repeat (20) @(negedge clk);
        n_chk++;
        if (out_q.size() != 0 || vwr_cnt != 0) begin
            n_fail++; $display("FAIL ready_low_quiet: got %0d words expected 0", out_q.size());
        end
        @(posedge clk); #1;
        bus.pktout_ready = 1;
        repeat (10) @(negedge clk);
        n_chk++;
        if (out_q.size() != 3) begin
            n_fail++; $display("FAIL ready_low_count: got %0d expected 3", out_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_chk++;
                if (out_q[i].d !== mk(typ(i, 3), 500 + i)) begin
                    n_fail++; $display("FAIL ready_low_data[%0d]: got %0h expected %0h", i, out_q[i].d, mk(typ(i, 3), 500 + i));
                end
            end
            n_chk++;
            if (out_q[2].vwr !== 1'b1 || out_q[2].v !== 1'b1) begin
                n_fail++; $display("FAIL ready_low_tail: got %b%b expected 11", out_q[2].vwr, out_q[2].v);
            end
        end
    endtask

    task automatic test_alf();
        do_reset();
        for (int i = 0; i < 127; i++) drv(1, mk(2'b11, i), 0, 0, 0, '0, 0, 0);
        drv_idle();
        @(negedge clk);
        n_chk++;
        if (bus.port_alf !== 1'b0) begin
            n_fail++; $display("FAIL alf_127: got %b expected 0", bus.port_alf);
        end
        drv(1, mk(2'b11, 127), 0, 0, 0, '0, 0, 0);
        drv_idle();
        @(negedge clk);
        n_chk++;
        if (bus.port_alf !== 1'b1) begin
            n_fail++; $display("FAIL alf_128: got %b expected 1", bus.port_alf);
        end
        drv(1, mk(2'b11, 128), 0, 0, 0, '0, 0, 0);
        drv_idle();
        @(negedge clk);
        n_chk++;
        if (bus.port_alf !== 1'b1 || bus.cpu_alf !== 1'b0) begin
            n_fail++; $display("FAIL alf_129: got port %b cpu %b expected port 1 cpu 0", bus.port_alf, bus.cpu_alf);
        end
    endtask

    task automatic test_ovf();
        do_reset();
        for (int i = 0; i < 256; i++) drv(0, '0, 0, 0, 1, mk(typ(i, 256), 3000 + i), 0, 0);
        drv_idle();
        @(negedge clk);
        n_chk++;
        if (bus.cpu_ovf !== 1'b0) begin
            n_fail++; $display("FAIL ovf_full_no_ovf: got %b expected 0", bus.cpu_ovf);
        end
        drv(0, '0, 0, 0, 1, mk(2'b01, 9999), 0, 0);
        drv_idle();
        @(negedge clk);
        n_chk++;
        if (bus.cpu_ovf !== 1'b1 || bus.port_ovf !== 1'b0) begin
            n_fail++; $display("FAIL ovf_set: got cpu %b port %b expected cpu 1 port 0", bus.cpu_ovf, bus.port_ovf);
        end
        drv(0, '0, 0, 0, 0, '0, 1, 1);
        drv_idle();
        repeat (5) @(negedge clk);
        n_chk++;
        if (bus.cpu_ovf !== 1'b1) begin
            n_fail++; $display("FAIL ovf_sticky: got %b expected 1", bus.cpu_ovf);
        end
        @(posedge clk); #1;
        bus.pktout_ready = 1;
        repeat (280) @(negedge clk);
        n_chk++;
        if (out_q.size() != 256) begin
            n_fail++; $display("FAIL ovf_drain_count: got %0d expected 256", out_q.size());
        end else begin
            for (int i = 0; i < 256; i++) begin
                n_chk++;
                if (out_q[i].d !== mk(typ(i, 256), 3000 + i)) begin
                    n_fail++; $display("FAIL ovf_data[%0d]: got %0h expected %0h", i, out_q[i].d, mk(typ(i, 256), 3000 + i));
                end
            end
            n_chk++;
            if (out_q[255].vwr !== 1'b1 || out_q[255].v !== 1'b1) begin
                n_fail++; $display("FAIL ovf_tail: got %b%b expected 11", out_q[255].vwr, out_q[255].v);
            end
        end
        n_chk++;
        if (bus.cpu_ovf !== 1'b1) begin
            n_fail++; $display("FAIL ovf_after_drain: got %b expected 1", bus.cpu_ovf);
        end
    endtask

    task automatic test_stats();
        int drops = 0;
        int n0 = 0;
        int waited = 0;
        logic [31:0] exp_p, exp_c;
`ifdef PKT_SRC_ARB_STATS_EN
        exp_p = 32'd3; exp_c = 32'd2;
`else
        exp_p = 32'd0; exp_c = 32'd0;
`endif
        do_reset();
        bus.pktout_ready = 1;
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 2; i++)
                drv(1, mk(typ(i, 2), 4000 + p * 10 + i), i == 1, 1,
                    p < 2, mk(typ(i, 2), 5000 + p * 10 + i), (p < 2) && (i == 1), p == 0);
        drv_idle();
        repeat (40) @(negedge clk);
        n_chk++;
        if (out_q.size() != 10 || vwr_cnt != 5) begin
            n_fail++; $display("FAIL stats_traffic: got %0d words %0d tails expected 10 words 5 tails", out_q.size(), vwr_cnt);
        end
        foreach (out_q[k]) if (out_q[k].vwr && !out_q[k].v) drops++;
        n_chk++;
        if (drops != 1) begin
            n_fail++; $display("FAIL stats_drop_flag: got %0d drop tails expected 1", drops);
        end
        n_chk++;
        if (bus.port_pkt_cnt !== exp_p || bus.cpu_pkt_cnt !== exp_c) begin
            n_fail++; $display("FAIL stats_cnt: got %0d/%0d expected %0d/%0d",
                bus.port_pkt_cnt, bus.cpu_pkt_cnt, exp_p, exp_c);
        end

        out_q.delete();
        for (int i = 0; i < 8; i++) drv(1, mk(typ(i, 8), 6000 + i), i == 7, 1, 0, '0, 0, 0);
        drv_idle();
        while (out_q.size() < 2 && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        n_chk++;
        if (out_q.size() < 2) begin
            n_fail++; $display("FAIL midpkt_start: got %0d words expected >= 2 within 30 cycles", out_q.size());
        end
        #2;
        rst_n = 0;
        #1;
        n_chk++;
        if ({bus.pktout_data_wr, bus.pktout_valid_wr} !== 2'b00 ||
            {bus.port_pkt_cnt, bus.cpu_pkt_cnt} !== 64'd0) begin
            n_fail++; $display("FAIL midpkt_reset: got wr %b%b cnt %0d/%0d expected 00 0/0",
                bus.pktout_data_wr, bus.pktout_valid_wr, bus.port_pkt_cnt, bus.cpu_pkt_cnt);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        vwr_cnt = 0;
        n0 = out_q.size();
        repeat (30) @(negedge clk);
        n_chk++;
        if (out_q.size() != n0 || vwr_cnt != 0) begin
            n_fail++; $display("FAIL midpkt_no_tail: got %0d words %0d tails expected 0 0", out_q.size() - n0, vwr_cnt);
        end
        n_chk++;
        if ({bus.port_pkt_cnt, bus.cpu_pkt_cnt} !== 64'd0) begin
            n_fail++; $display("FAIL midpkt_cnt: got %0d/%0d expected 0/0", bus.port_pkt_cnt, bus.cpu_pkt_cnt);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_port();
        test_round_robin();
        test_ready_low();
        test_alf();
        test_ovf();
        test_stats();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
